// File: rtl/median_filter_arbiter_if.sv
// Handshake/bus bundle for median_filter_arbiter: strobed sample inputs and
// filtered outputs. The slave modport is the filter, master is its driver.
interface median_filter_arbiter_if #(
    parameter int CHANNELS = 4
);
    localparam int CHW = $clog2(CHANNELS);

    logic [CHANNELS-1:0] sample_stb;
    logic [CHANNELS-1:0] bit_in;
    logic                hist_clr;
    logic [CHANNELS-1:0] ovr_clr;
    logic [CHANNELS-1:0] bit_out;
    logic                out_valid;
    logic [CHW-1:0]      out_ch;
    logic [CHANNELS-1:0] overrun;
    logic                busy;

    modport master (
        output sample_stb, bit_in, hist_clr, ovr_clr,
        input  bit_out, out_valid, out_ch, overrun, busy
    );

    modport slave (
        input  sample_stb, bit_in, hist_clr, ovr_clr,
        output bit_out, out_valid, out_ch, overrun, busy
    );
endinterface

// File: rtl/median_filter_arbiter.sv
// Time-shared majority-vote bit filter: one popcount engine serves CHANNELS histories
// via a round-robin arbiter. Optional feature macro: MEDIAN_FILTER_ARB_OVERRUN_EN.
module median_filter_arbiter #(
    parameter int CHANNELS    = 4,
    parameter int FILTER_SIZE = 8,
    parameter int COMP_NUMBER = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    median_filter_arbiter_if.slave bus
);
    localparam int CHW  = $clog2(CHANNELS);
    localparam int CNTW = $clog2(FILTER_SIZE + 1);

    logic [CHANNELS-1:0]    r_pending;
    logic [CHANNELS-1:0]    r_pbit;
    logic [FILTER_SIZE-1:0] r_hist [CHANNELS];
    logic [CHANNELS-1:0]    r_bit_out;
    logic [CHW-1:0]         r_last_grant;
    logic                   r_s1_valid;
    logic [CHW-1:0]         r_s1_ch;
    logic                   r_out_valid;
    logic [CHW-1:0]         r_out_ch;

    logic                   w_grant_valid;
    logic [CHW-1:0]         w_grant_ch;
    logic [CHW-1:0]         w_idx;
    logic [CHANNELS-1:0]    w_grant_oh;
    logic [CNTW-1:0]        w_ones;
    logic                   w_hit;

    // Walk from farthest to nearest so the channel closest after last_grant wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_ch    = '0;
        w_idx         = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            w_idx = CHW'((int'(r_last_grant) + k) % CHANNELS);
            if (r_pending[w_idx] && !bus.hist_clr) begin
                w_grant_valid = 1'b1;
                w_grant_ch    = w_idx;
            end
        end
        w_grant_oh = '0;
        if (w_grant_valid) begin
            w_grant_oh[w_grant_ch] = 1'b1;
        end
    end

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < FILTER_SIZE; i++) begin
            w_ones = w_ones + CNTW'(r_hist[r_s1_ch][i]);
        end
        w_hit = (w_ones >= CNTW'(COMP_NUMBER));
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pending[gi] <= 1'b0;
                    r_pbit[gi]    <= 1'b0;
                    r_hist[gi]    <= '0;
                end else if (bus.hist_clr) begin
                    r_pending[gi] <= 1'b0;
                    r_hist[gi]    <= '0;
                end else begin
                    // A strobe in the grant cycle re-arms the channel with the new bit.
                    if (bus.sample_stb[gi]) begin
                        r_pending[gi] <= 1'b1;
                        r_pbit[gi]    <= bus.bit_in[gi];
                    end else if (w_grant_oh[gi]) begin
                        r_pending[gi] <= 1'b0;
                    end
                    if (w_grant_oh[gi]) begin
                        r_hist[gi] <= {r_pbit[gi], r_hist[gi][FILTER_SIZE-1:1]};
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_bit_out[gi] <= 1'b0;
                end else if (bus.hist_clr) begin
                    r_bit_out[gi] <= 1'b0;
                end else if (r_s1_valid && (r_s1_ch == CHW'(gi))) begin
                    r_bit_out[gi] <= w_hit;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= CHW'(CHANNELS - 1);
            r_s1_valid   <= 1'b0;
            r_s1_ch      <= '0;
            r_out_valid  <= 1'b0;
            r_out_ch     <= '0;
        end else begin
            if (w_grant_valid) begin
                r_last_grant <= w_grant_ch;
                r_s1_ch      <= w_grant_ch;
            end
            r_s1_valid  <= w_grant_valid;
            r_out_valid <= r_s1_valid && !bus.hist_clr;
            if (r_s1_valid && !bus.hist_clr) begin
                r_out_ch <= r_s1_ch;
            end
        end
    end

`ifdef MEDIAN_FILTER_ARB_OVERRUN_EN
    logic [CHANNELS-1:0] r_overrun;

    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ovr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_overrun[gi] <= 1'b0;
                end else if (!bus.hist_clr && bus.sample_stb[gi] && r_pending[gi] && !w_grant_oh[gi]) begin
                    r_overrun[gi] <= 1'b1;
                end else if (bus.ovr_clr[gi]) begin
                    r_overrun[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.overrun = r_overrun;
`else
    logic w_unused_ovr_clr;
    assign w_unused_ovr_clr = ^bus.ovr_clr;
    assign bus.overrun      = '0;
`endif

    assign bus.bit_out   = r_bit_out;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.busy      = (|r_pending) | r_s1_valid | r_out_valid;
endmodule

// File: tb/tb_median_filter_arbiter.sv
// Self-checking bench for median_filter_arbiter: directed scenarios plus random
// traffic, compared every cycle against a behavioural model of the filter.
module tb_median_filter_arbiter;
    localparam int C    = 4;
    localparam int FS   = 8;
    localparam int COMP = 4;
`ifdef MEDIAN_FILTER_ARB_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    median_filter_arbiter_if #(.CHANNELS(C)) bus ();

    median_filter_arbiter #(.CHANNELS(C), .FILTER_SIZE(FS), .COMP_NUMBER(COMP)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: pending slots, histories as bit vectors (newest at MSB).
    bit          m_pend [C];
    bit          m_pbit [C];
    bit [FS-1:0] m_hist [C];
    bit [C-1:0]  m_bo   = '0;
    bit [C-1:0]  m_ov   = '0;
    int          m_lg   = C - 1;
    bit          m_s1v  = 1'b0;
    int          m_s1ch = 0;
    bit          m_ovld = 1'b0;
    int          m_och  = 0;
    int          m_g;
    int          m_idx;

    task automatic model_reset();
        for (int c = 0; c < C; c++) begin
            m_pend[c] = 1'b0;
            m_pbit[c] = 1'b0;
            m_hist[c] = '0;
        end
        m_bo = '0; m_ov = '0; m_lg = C - 1;
        m_s1v = 1'b0; m_s1ch = 0; m_ovld = 1'b0; m_och = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            m_g = -1;
            if (!bus.hist_clr) begin
                for (int k = 1; k <= C; k++) begin
                    m_idx = (m_lg + k) % C;
                    if (m_g < 0 && m_pend[m_idx]) m_g = m_idx;
                end
            end
            for (int c = 0; c < C; c++) begin
                if (OVR_EN && !bus.hist_clr && bus.sample_stb[c] && m_pend[c] && m_g != c)
                    m_ov[c] = 1'b1;
                else if (OVR_EN && bus.ovr_clr[c])
                    m_ov[c] = 1'b0;
            end
            if (bus.hist_clr) begin
                for (int c = 0; c < C; c++) begin
                    m_pend[c] = 1'b0;
                    m_hist[c] = '0;
                end
                m_bo = '0; m_s1v = 1'b0; m_ovld = 1'b0;
            end else begin
                if (m_s1v) begin
                    m_bo[m_s1ch] = ($countones(m_hist[m_s1ch]) >= COMP);
                    m_och = m_s1ch;
                end
                m_ovld = m_s1v;
                if (m_g >= 0) begin
                    m_hist[m_g] = (m_hist[m_g] >> 1) | (FS'(m_pbit[m_g]) << (FS - 1));
                    m_s1ch = m_g;
                    m_lg = m_g;
                end
                m_s1v = (m_g >= 0);
                for (int c = 0; c < C; c++) begin
                    if (bus.sample_stb[c]) begin
                        m_pend[c] = 1'b1;
                        m_pbit[c] = bus.bit_in[c];
                    end else if (m_g == c) begin
                        m_pend[c] = 1'b0;
                    end
                end
            end
        end
    end

    function automatic bit model_busy();
        bit b;
        b = m_s1v | m_ovld;
        for (int c = 0; c < C; c++) b |= m_pend[c];
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Single compare process against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_bit_out",   32'(bus.bit_out),   32'(m_bo));
            chk("m_out_valid", 32'(bus.out_valid), 32'(m_ovld));
            chk("m_overrun",   32'(bus.overrun),   32'(m_ov));
            chk("m_busy",      32'(bus.busy),      32'(model_busy()));
            if (m_ovld) chk("m_out_ch", 32'(bus.out_ch), 32'(m_och));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int q_ch[$];
    int svc;

    initial begin
        bus.sample_stb = '0; bus.bit_in = '0; bus.hist_clr = 1'b0; bus.ovr_clr = '0;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_bit_out", 32'(bus.bit_out), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        rst_n = 1'b1;

        // Single channel: 8 ones then 5 zeros on ch1.
        for (int i = 0; i < 13; i++) begin
            bus.sample_stb = 4'b0010; bus.bit_in = (i < 8) ? 4'b0010 : 4'b0000;
            cyc();
            bus.sample_stb = '0;
            cyc();
            chk("lat_early", 32'(bus.out_valid), 0);
            cyc();
            chk("lat_valid", 32'(bus.out_valid), 1);
            chk("lat_ch", 32'(bus.out_ch), 1);
            chk("ch1_level", 32'(bus.bit_out[1]), (i >= 3 && i < 12) ? 1 : 0);
        end
        cyc();

        // All four channels at once after reset.
        do_reset();
        bus.sample_stb = 4'hF; bus.bit_in = 4'h5;
        cyc();
        bus.sample_stb = '0;
        q_ch.delete();
        for (int t = 0; t < 8; t++) begin
            cyc();
            if (bus.out_valid) q_ch.push_back(int'(bus.out_ch));
        end
        chk("rr_count", q_ch.size(), 4);
        for (int i = 0; i < 4; i++) chk("rr_order", (i < q_ch.size()) ? q_ch[i] : 99, i);
        chk("rr_busy_end", 32'(bus.busy), 0);

        // Ch2 overwritten while waiting behind ch0/ch1.
        do_reset();
        bus.sample_stb = 4'hF; bus.bit_in = 4'h0;
        cyc();
        bus.sample_stb = '0;
        cyc();
        bus.sample_stb = 4'b0100; bus.bit_in = 4'b0100;
        cyc();
        bus.sample_stb = '0;
        svc = 0;
        for (int t = 0; t < 8; t++) begin
            cyc();
            if (bus.out_valid && bus.out_ch == 2) svc++;
        end
        chk("ovr_services", svc, 1);
        chk("ovr_flag", 32'(bus.overrun[2]), 32'(OVR_EN));
        bus.ovr_clr = 4'b0100;
        cyc();
        bus.ovr_clr = '0;
        chk("ovr_clear", 32'(bus.overrun[2]), 0);

        // Strobe on ch0 during its own grant cycle.
        do_reset();
        bus.sample_stb = 4'b0001; bus.bit_in = 4'b0001;
        cyc();
        cyc();
        bus.sample_stb = '0;
        svc = 0;
        for (int t = 0; t < 8; t++) begin
            if (bus.out_valid && bus.out_ch == 0) svc++;
            cyc();
        end
        chk("same_cyc_services", svc, 2);
        chk("same_cyc_ovr", 32'(bus.overrun[0]), 0);

        // hist_clr during continuous ones.
        do_reset();
        bus.sample_stb = 4'hF; bus.bit_in = 4'hF;
        repeat (30) cyc();
        chk("pre_clr_level", 32'(bus.bit_out), 32'hF);
        bus.hist_clr = 1'b1;
        cyc();
        bus.hist_clr = 1'b0; bus.sample_stb = '0;
        chk("clr_bit_out", 32'(bus.bit_out), 0);
        chk("clr_out_valid", 32'(bus.out_valid), 0);
        chk("clr_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 4; i++) begin
            bus.sample_stb = 4'b0001; bus.bit_in = 4'b0001;
            cyc();
            bus.sample_stb = '0;
            cyc(); cyc();
            chk("clr_restart", 32'(bus.bit_out[0]), (i == 3) ? 1 : 0);
        end

        // Asynchronous reset mid-burst.
        bus.sample_stb = 4'hF; bus.bit_in = 4'hF;
        repeat (25) cyc();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_bit_out", 32'(bus.bit_out), 0);
        chk("async_out_valid", 32'(bus.out_valid), 0);
        chk("async_busy", 32'(bus.busy), 0);
        chk("async_overrun", 32'(bus.overrun), 0);
        @(negedge clk);
        bus.sample_stb = '0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.sample_stb = 4'b1000; bus.bit_in = 4'b1000;
        cyc();
        bus.sample_stb = '0;
        cyc(); cyc();
        chk("post_rst_valid", 32'(bus.out_valid), 1);
        chk("post_rst_ch", 32'(bus.out_ch), 3);

        // Random traffic; the compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            bus.sample_stb = C'($urandom_range(0, 15) & $urandom_range(0, 15));
            bus.bit_in     = ((i / 200) % 2 == 1) ? C'($urandom & $urandom) : C'($urandom | $urandom);
            bus.hist_clr   = ($urandom_range(0, 63) == 0);
            bus.ovr_clr    = ($urandom_range(0, 15) == 0) ? C'($urandom) : '0;
            cyc();
        end
        bus.sample_stb = '0; bus.hist_clr = 1'b0; bus.ovr_clr = '0;
        repeat (10) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
